// File: rtl/addr_increment_2d_pkg.sv
// Shared defaults and width helper for the 2D address generator.
// Used by wrap_counter and addr_increment_2d.
package addr_gen_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 17;
    localparam int DEFAULT_H_COUNT    = 320;
    localparam int DEFAULT_V_COUNT    = 240;
    localparam int DEFAULT_INCR_AMT   = 1;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/addr_increment_2d_wrap_counter.sv
// Modulo-MAX counter with synchronous clear and enable.
// wrap_out is combinational: high in the cycle an enabled count
// rolls over from MAX-1 to 0, so the parent can cascade counters.
module wrap_counter
    import addr_gen_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        clr_in,
    input  logic                        en_in,
    output logic [clog2_min1(MAX)-1:0]  count_out,
    output logic                        wrap_out
);

    localparam int W = clog2_min1(MAX);
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic at_last;

    assign at_last  = (count_out == LAST);
    assign wrap_out = en_in && at_last;

    // Count 0..MAX-1; clear wins over enable.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_out <= '0;
        end else if (clr_in) begin
            count_out <= '0;
        end else if (en_in) begin
            count_out <= at_last ? '0 : count_out + W'(1);
        end
    end

endmodule

// File: rtl/addr_increment_2d.sv
// Raster address generator: walks H_COUNT columns by INCR_AMT and
// V_COUNT lines by LINE_STRIDE, with optional ping-pong frame buffers.
// Optional feature macro: ADDR_INC_DOUBLE_BUFFER_EN (toggle buf_sel_out
// on each frame wrap; otherwise buf_sel_out is tied to 0).
//
// Control: incr_in and calib_in are single-cycle level qualifiers sampled
// on each rising clk_in edge (no ready; always accepted). calib_in beats
// incr_in. All outputs are registered and reflect the request one cycle
// later; line_end_out/frame_end_out are one-cycle pulses.
module addr_increment_2d
    import addr_gen_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int H_COUNT     = DEFAULT_H_COUNT,
    parameter int V_COUNT     = DEFAULT_V_COUNT,
    parameter int INCR_AMT    = DEFAULT_INCR_AMT,
    parameter int LINE_STRIDE = H_COUNT * INCR_AMT,
    parameter int BASE_ADDR   = 0
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            calib_in,
    input  logic                            incr_in,
    output logic [ADDR_WIDTH-1:0]           addr_out,
    output logic [clog2_min1(H_COUNT)-1:0]  hcount_out,
    output logic [clog2_min1(V_COUNT)-1:0]  vcount_out,
    output logic                            line_end_out,
    output logic                            frame_end_out,
    output logic                            buf_sel_out
);

`ifdef ADDR_INC_DOUBLE_BUFFER_EN
    localparam int DB = 1;
`else
    localparam int DB = 0;
`endif

    localparam int FRAME_WORDS = V_COUNT * LINE_STRIDE;
    localparam longint ADDR_SPAN = longint'(1) << ADDR_WIDTH;
    localparam longint LAST_WORD = longint'(BASE_ADDR)
                                 + longint'(FRAME_WORDS) * (1 + DB) - 1;

    // Reject configurations whose frames overflow the address space or
    // whose line stride would overlap the next line.
    if (LAST_WORD >= ADDR_SPAN) begin : g_bad_span
        $error("addr_increment_2d: frame buffer(s) exceed ADDR_WIDTH");
    end
    if (LINE_STRIDE < H_COUNT * INCR_AMT) begin : g_bad_stride
        $error("addr_increment_2d: LINE_STRIDE shorter than one line");
    end

    localparam logic [ADDR_WIDTH-1:0] FB0      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] INCR_A   = ADDR_WIDTH'(INCR_AMT);
    localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(LINE_STRIDE);

    logic                  col_en;
    logic                  col_wrap;
    logic                  line_wrap;
    logic [ADDR_WIDTH-1:0] line_start;
    logic [ADDR_WIDTH-1:0] cur_fb;
    logic [ADDR_WIDTH-1:0] next_fb;

    assign col_en = incr_in && !calib_in;

    wrap_counter #(.MAX(H_COUNT)) u_col (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clr_in    (calib_in),
        .en_in     (col_en),
        .count_out (hcount_out),
        .wrap_out  (col_wrap)
    );

    wrap_counter #(.MAX(V_COUNT)) u_line (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clr_in    (calib_in),
        .en_in     (col_wrap),
        .count_out (vcount_out),
        .wrap_out  (line_wrap)
    );

`ifdef ADDR_INC_DOUBLE_BUFFER_EN
    localparam logic [ADDR_WIDTH-1:0] FB1 = ADDR_WIDTH'(BASE_ADDR + FRAME_WORDS);

    assign cur_fb  = buf_sel_out ? FB1 : FB0;
    assign next_fb = buf_sel_out ? FB0 : FB1;

    // Flip the active buffer on every frame wrap.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            buf_sel_out <= 1'b0;
        end else if (line_wrap) begin
            buf_sel_out <= !buf_sel_out;
        end
    end
`else
    assign cur_fb      = FB0;
    assign next_fb     = FB0;
    assign buf_sel_out = 1'b0;
`endif

    // Address walk: step within a line, jump from the remembered line
    // start at line wrap, restart at a frame base on frame wrap or calib.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            addr_out      <= FB0;
            line_start    <= FB0;
            line_end_out  <= 1'b0;
            frame_end_out <= 1'b0;
        end else begin
            line_end_out  <= 1'b0;
            frame_end_out <= 1'b0;
            if (calib_in) begin
                addr_out   <= cur_fb;
                line_start <= cur_fb;
            end else if (incr_in) begin
                if (col_wrap) begin
                    line_end_out <= 1'b1;
                    if (line_wrap) begin
                        frame_end_out <= 1'b1;
                        addr_out      <= next_fb;
                        line_start    <= next_fb;
                    end else begin
                        addr_out   <= line_start + STRIDE_A;
                        line_start <= line_start + STRIDE_A;
                    end
                end else begin
                    addr_out <= addr_out + INCR_A;
                end
            end
        end
    end

endmodule

// File: tb/tb_addr_increment_2d.sv
// Bench for addr_increment_2d: 8-bit addresses, 4x3 raster, step 2,
// stride 10, base 100. Build with ADDR_INC_DOUBLE_BUFFER_EN to exercise
// the ping-pong buffer path.
module tb_addr_increment_2d;

    localparam int AW     = 8;
    localparam int HC     = 4;
    localparam int VC     = 3;
    localparam int STEP   = 2;
    localparam int STRIDE = 10;
    localparam int BASE   = 100;
    localparam int FWORDS = VC * STRIDE;
`ifdef ADDR_INC_DOUBLE_BUFFER_EN
    localparam int DB = 1;
`else
    localparam int DB = 0;
`endif
    localparam int EW = AW + 2 + 2 + 3;

    logic          clk;
    logic          rst;
    logic          calib;
    logic          incr;
    logic [AW-1:0] addr;
    logic [1:0]    hcount;
    logic [1:0]    vcount;
    logic          line_end;
    logic          frame_end;
    logic          buf_sel;

    int checks = 0;
    int errors = 0;

    // model state
    int m_h, m_v, m_buf;
    logic m_le, m_fe;

    logic [EW-1:0] exp_q[$];

    addr_increment_2d #(
        .ADDR_WIDTH  (AW),
        .H_COUNT     (HC),
        .V_COUNT     (VC),
        .INCR_AMT    (STEP),
        .LINE_STRIDE (STRIDE),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .calib_in      (calib),
        .incr_in       (incr),
        .addr_out      (addr),
        .hcount_out    (hcount),
        .vcount_out    (vcount),
        .line_end_out  (line_end),
        .frame_end_out (frame_end),
        .buf_sel_out   (buf_sel)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic [EW-1:0] model_vec();
        int a;
        logic [AW-1:0] a8;
        a  = BASE + m_buf * FWORDS + m_v * STRIDE + m_h * STEP;
        a8 = AW'(a);
        return {a8, 2'(m_h), 2'(m_v), m_le, m_fe, 1'(m_buf)};
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 0; m_buf = 0; m_le = 1'b0; m_fe = 1'b0;
    endtask

    task automatic model_step(input logic i, input logic c);
        m_le = 1'b0;
        m_fe = 1'b0;
        if (c) begin
            m_h = 0;
            m_v = 0;
        end else if (i) begin
            if (m_h == HC - 1) begin
                m_h  = 0;
                m_le = 1'b1;
                if (m_v == VC - 1) begin
                    m_v  = 0;
                    m_fe = 1'b1;
                    if (DB == 1) m_buf = 1 - m_buf;
                end else begin
                    m_v = m_v + 1;
                end
            end else begin
                m_h = m_h + 1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Apply one cycle of inputs; the expected post-edge state goes to exp_q.
    task automatic step(input logic i, input logic c);
        incr  = i;
        calib = c;
        @(posedge clk);
        #1;
        model_step(i, c);
        exp_q.push_back(model_vec());
        incr  = 1'b0;
        calib = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0);
    endtask

    // Direct check, used for asynchronous and literal expectations.
    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {addr, hcount, vcount, line_end, frame_end, buf_sel};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL sb t=%0t: got addr=%0d h=%0d v=%0d le=%b fe=%b bs=%b expected addr=%0d h=%0d v=%0d le=%b fe=%b bs=%b",
                         $time, a[EW-1 -: AW], a[6:5], a[4:3], a[2], a[1], a[0],
                         e[EW-1 -: AW], e[6:5], e[4:3], e[2], e[1], e[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int fb;
        rst   = 1'b1;
        calib = 1'b0;
        incr  = 1'b0;
        model_reset();

        // Reset before any clock edge.
        #2;
        chk("reset_addr", addr, 100);
        chk("reset_h", hcount, 0);
        chk("reset_v", vcount, 0);
        chk("reset_buf", buf_sel, 0);
        chk("reset_le", line_end, 0);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Line wrap: 102,104,106,110.
        steps(4);
        chk("line_wrap_addr", addr, 110);
        chk("line_wrap_v", vcount, 1);
        chk("line_wrap_le", line_end, 1);
        step(1'b1, 1'b0);                 // 112, le drops
        chk("le_one_cycle", line_end, 0);

        // Hold for three idle cycles mid-line.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        chk("hold_addr", addr, 112);

        // Priority: calib with incr at h=2, v=1.
        step(1'b1, 1'b0);                 // 114
        chk("pre_calib_h", hcount, 2);
        step(1'b1, 1'b1);
        chk("calib_addr", addr, 100);
        chk("calib_fe", frame_end, 0);

        // Frame wrap after 12 increments.
        steps(11);
        chk("pre_wrap_addr", addr, 126);
        step(1'b1, 1'b0);
        chk("frame_wrap_addr", addr, (DB == 1) ? 130 : 100);
        chk("frame_wrap_buf", buf_sel, DB);
        chk("frame_wrap_fe", frame_end, 1);
        chk("frame_wrap_le", line_end, 1);

        // Priority inside the current buffer.
        steps(6);                         // h=2, v=1
        step(1'b1, 1'b1);
        fb = (DB == 1) ? 130 : 100;
        chk("calib_buf_addr", addr, fb);

        // Return to buffer 0 if needed, then walk to addr 124.
        if (DB == 1) steps(12);
        steps(10);
        chk("pre_async_addr", addr, 124);

        // Asynchronous reset between edges.
        wait (exp_q.size() == 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_addr", addr, 100);
        chk("async_h", hcount, 0);
        chk("async_v", vcount, 0);
        chk("async_buf", buf_sel, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        steps(2);
        chk("after_reset_addr", addr, 104);

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addr_increment_2d.md
ADDR_INCREMENT_2D -- requirements
Module: addr_increment_2d

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 17: address output width.
REQ-002 SHALL have parameter H_COUNT, default 320: increments per line.
REQ-003 SHALL have parameter V_COUNT, default 240: lines per frame.
REQ-004 SHALL have parameter INCR_AMT, default 1: address step within a line.
REQ-005 SHALL have parameter LINE_STRIDE, default H_COUNT*INCR_AMT: address step between line starts; padding allowed.
REQ-006 SHALL have parameter BASE_ADDR, default 0: frame-0 start address.
REQ-007 SHALL have port clk_in, input, 1: the single clock; all logic on rising edge.
REQ-008 SHALL have port rst_in, input, 1: reset, asynchronous, active-high.
REQ-009 SHALL have port calib_in, input, 1: resynchronise to start of the current frame buffer.
REQ-010 SHALL have port incr_in, input, 1: advance one position.
REQ-011 SHALL have port addr_out, output, ADDR_WIDTH: current address, registered.
REQ-012 SHALL have port hcount_out, output, HW=clog2(H_COUNT): column index, registered.
REQ-013 SHALL have port vcount_out, output, VW=clog2(V_COUNT): line index, registered.
REQ-014 SHALL have port line_end_out, output, 1: one-cycle pulse on line wrap.
REQ-015 SHALL have port frame_end_out, output, 1: one-cycle pulse on frame wrap.
REQ-016 SHALL have port buf_sel_out, output, 1: active frame buffer index.

Function
REQ-017 SHALL define FRAME_WORDS = V_COUNT*LINE_STRIDE, frame base FB = BASE_ADDR + buf_sel_out*FRAME_WORDS.
REQ-018 SHALL, on incr_in with hcount<H_COUNT-1: hcount+1, addr += INCR_AMT, next cycle visible.
REQ-019 SHALL, on incr_in with hcount=H_COUNT-1 and vcount<V_COUNT-1: hcount=0, vcount+1, addr = previous line start + LINE_STRIDE; line_end_out=1 next cycle.
REQ-020 SHALL, on incr_in at last column of last line: hcount=0, vcount=0, addr=FB of the next buffer; line_end_out and frame_end_out both 1 next cycle.
REQ-021 SHALL hold all counters and addr when incr_in=0; pulses deassert after one cycle.
REQ-022 SHALL give calib_in priority over incr_in same cycle: hcount=0, vcount=0, addr=FB, buf_sel unchanged, no pulses.
REQ-023 SHALL compute addresses modulo 2^ADDR_WIDTH; one-cycle latency from incr_in/calib_in to outputs.
REQ-024 SHALL fail elaboration if BASE_ADDR+FRAME_WORDS*(1+DB)-1 >= 2^ADDR_WIDTH (DB=1 when double-buffer compiled), or LINE_STRIDE < H_COUNT*INCR_AMT.

Reset
REQ-025 SHALL, while rst_in=1, immediately force addr_out=BASE_ADDR, hcount=0, vcount=0, buf_sel_out=0, both pulses 0, independent of clk_in.
REQ-026 SHALL resume on the first clock edge after rst_in falls; reset mid-line discards position.

Configuration
REQ-027 SHALL honour macro ADDR_INC_DOUBLE_BUFFER_EN: when defined, buf_sel_out toggles on each frame wrap (REQ-020).
REQ-028 SHALL, without ADDR_INC_DOUBLE_BUFFER_EN, tie buf_sel_out to 0; frame wrap returns to BASE_ADDR.

Structure
REQ-029 SHALL place default dimensions and a width helper function (clog2, minimum 1) in package addr_gen_pkg.
REQ-030 SHALL build column and line counters from one sub-module wrap_counter (parameter MAX, ports clk_in, rst_in, clr_in, en_in, count_out, wrap_out).

Verification (ADDR_WIDTH=8, H_COUNT=4, V_COUNT=3, INCR_AMT=2, LINE_STRIDE=10, BASE_ADDR=100)
REQ-031 SHALL check reset: rst_in=1 without clock -> addr=100, hcount=0, vcount=0, buf_sel=0.
REQ-032 SHALL check line wrap: 4 incr -> addr 102,104,106,110; line_end_out pulses once after 4th; vcount=1.
REQ-033 SHALL check frame wrap: 12 incr from reset -> line_end+frame_end pulse together; addr=130, buf_sel=1 with macro; addr=100, buf_sel=0 without.
REQ-034 SHALL check priority: calib_in=1 with incr_in=1 at hcount=2, vcount=1 -> addr=FB (100 or 130), counts 0, no pulses.
REQ-035 SHALL check holds: incr_in=0 for 3 cycles mid-line -> addr, counts unchanged, pulses 0.
REQ-036 SHALL check async reset mid-frame: rst_in asserted between edges at addr=124 -> addr=100 before next edge.
